// File: rtl/sealing_station_ctrl_pkg.sv
// Shared types for the bottle sealing station: FSM state encoding and fault codes.
package sealing_station_ctrl_pkg;

    typedef enum logic [2:0] {
        StStop    = 3'd0,
        StRun     = 3'd1,
        StAlign   = 3'd2,
        StSeal    = 3'd3,
        StRelease = 3'd4,
        StEmpty   = 3'd5,
        StFault   = 3'd6
    } state_e;

    localparam logic [1:0] FaultNone  = 2'd0;
    localparam logic [1:0] FaultAlign = 2'd1;
    localparam logic [1:0] FaultSeal  = 2'd2;

endpackage

// File: rtl/sealing_station_ctrl_if.sv
// Conveyor, sensor, actuator and panel signals of the sealing station.
interface sealing_station_ctrl_if #(
    parameter int unsigned CORK_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic              clear;
    logic              bottle;
    logic              pos;
    logic              seal_ack;
    logic              refill_ack;
    logic [CORK_W-1:0] refill_qty;
    logic              motor_on;
    logic              seal_req;
    logic              refill_req;
    logic              alarm;
    logic [1:0]        fault_code;
    logic [CORK_W-1:0] cork_count;
    logic [CNT_W-1:0]  sealed_cnt;

    modport master (
        output start, clear, bottle, pos, seal_ack, refill_ack, refill_qty,
        input  motor_on, seal_req, refill_req, alarm, fault_code, cork_count, sealed_cnt
    );

    modport slave (
        input  start, clear, bottle, pos, seal_ack, refill_ack, refill_qty,
        output motor_on, seal_req, refill_req, alarm, fault_code, cork_count, sealed_cnt
    );
endinterface

// File: rtl/sealing_cork_stock.sv
// Cork stock counter: decrement per seal, saturating refill load.
module sealing_cork_stock #(
    parameter int unsigned CORK_W   = 8,
    parameter int unsigned CORK_MAX = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_dec,
    input  logic              i_load,
    input  logic [CORK_W-1:0] i_qty,
    output logic [CORK_W-1:0] o_count,
    output logic [CORK_W-1:0] o_load_val
);
    localparam logic [CORK_W:0]   MAX_WIDE   = (CORK_W + 1)'(CORK_MAX);
    localparam logic [CORK_W-1:0] MAX_NARROW = CORK_W'(CORK_MAX);

    logic [CORK_W-1:0] r_count;
    logic [CORK_W-1:0] w_count_d;
    logic [CORK_W:0]   w_sum;

    // Extra bit keeps a large refill from wrapping before saturation.
    assign w_sum      = {1'b0, r_count} + {1'b0, i_qty};
    assign o_load_val = (w_sum > MAX_WIDE) ? MAX_NARROW : w_sum[CORK_W-1:0];
    assign o_count    = r_count;

    always_comb begin
        w_count_d = r_count;
        if (i_load) begin
            w_count_d = o_load_val;
        end else if (i_dec && (r_count != '0)) begin
            w_count_d = r_count - CORK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end
endmodule

// File: rtl/sealing_station_ctrl.sv
// Bottle sealing station sequencer: conveyor stop, alignment wait, seal handshake, cork refill.
module sealing_station_ctrl
    import sealing_station_ctrl_pkg::*;
#(
    parameter int unsigned CORK_W   = 8,
    parameter int unsigned CORK_MAX = 100,
    parameter int unsigned ALIGN_TO = 15,
    parameter int unsigned SEAL_TO  = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    sealing_station_ctrl_if.slave bus
);
    localparam int unsigned TMR_MAX = (ALIGN_TO > SEAL_TO) ? ALIGN_TO : SEAL_TO;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ALIGN_LIM = TMR_W'(ALIGN_TO);
    localparam logic [TMR_W-1:0] SEAL_LIM  = TMR_W'(SEAL_TO);

    state_e            r_state, w_state_d;
    logic [TMR_W-1:0]  r_timer, w_timer_d;
    logic [1:0]        r_fault, w_fault_d;
    logic [CNT_W-1:0]  r_sealed, w_sealed_d;
    logic              w_dec, w_load;
    logic [CORK_W-1:0] w_cork, w_cork_load;

    sealing_cork_stock #(
        .CORK_W   (CORK_W),
        .CORK_MAX (CORK_MAX)
    ) u_cork_stock (
        .clk        (clk),
        .reset      (reset),
        .i_dec      (w_dec),
        .i_load     (w_load),
        .i_qty      (bus.refill_qty),
        .o_count    (w_cork),
        .o_load_val (w_cork_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StStop;
            r_timer  <= '0;
            r_fault  <= FaultNone;
            r_sealed <= '0;
        end else begin
            r_state  <= w_state_d;
            r_timer  <= w_timer_d;
            r_fault  <= w_fault_d;
            r_sealed <= w_sealed_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_timer_d  = r_timer;
        w_fault_d  = r_fault;
        w_sealed_d = r_sealed;
        w_dec      = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            StStop: begin
                if (bus.start) w_state_d = (w_cork == '0) ? StEmpty : StRun;
            end
            StRun: begin
                if (!bus.start) begin
                    w_state_d = StStop;
                end else if (bus.bottle) begin
                    w_state_d = StAlign;
                    w_timer_d = '0;
                end
            end
            StAlign: begin
                // Alignment arriving on the last allowed cycle still counts.
                if (bus.pos) begin
                    w_state_d = StSeal;
                    w_timer_d = '0;
                end else if (r_timer == ALIGN_LIM) begin
                    w_state_d = StFault;
                    w_fault_d = FaultAlign;
                end else begin
                    w_timer_d = r_timer + TMR_W'(1);
                end
            end
            StSeal: begin
                if (bus.seal_ack) begin
                    w_state_d  = StRelease;
                    w_dec      = 1'b1;
                    w_sealed_d = r_sealed + CNT_W'(1);
                end else if (r_timer == SEAL_LIM) begin
                    w_state_d = StFault;
                    w_fault_d = FaultSeal;
                end else begin
                    w_timer_d = r_timer + TMR_W'(1);
                end
            end
            StRelease: begin
                if (!bus.bottle) w_state_d = (w_cork == '0) ? StEmpty : StRun;
            end
            StEmpty: begin
                if (bus.refill_ack) begin
                    w_load = 1'b1;
                    if (w_cork_load != '0) w_state_d = bus.start ? StRun : StStop;
                end
            end
            StFault: begin
                if (bus.clear) begin
                    w_state_d = StStop;
                    w_fault_d = FaultNone;
                end
            end
            default: w_state_d = StStop;
        endcase
    end

    always_comb begin
        bus.motor_on   = 1'b0;
        bus.seal_req   = 1'b0;
        bus.refill_req = 1'b0;
        bus.alarm      = 1'b0;
        case (r_state)
            StRun, StRelease: bus.motor_on = 1'b1;
            StSeal:           bus.seal_req = 1'b1;
            StEmpty: begin
                bus.refill_req = 1'b1;
                bus.alarm      = 1'b1;
            end
            StFault:          bus.alarm = 1'b1;
            default: ;
        endcase
    end

    assign bus.fault_code = r_fault;
    assign bus.cork_count = w_cork;
    assign bus.sealed_cnt = r_sealed;
endmodule

// File: tb/tb_sealing_station_ctrl.sv
// Vector-table and scoreboard bench for sealing_station_ctrl.
module tb_sealing_station_ctrl;

    typedef struct packed {
        logic        motor;
        logic        sreq;
        logic        rreq;
        logic        alarm;
        logic [1:0]  fc;
        logic [7:0]  cork;
        logic [15:0] sealed;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] in;   // start, clear, bottle, pos, seal_ack, refill_ack
        logic [7:0] qty;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    vec_t tbl[$];

    sealing_station_ctrl_if #(.CORK_W(8), .CNT_W(16)) bus ();

    sealing_station_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic [5:0] in, logic [7:0] q, logic [3:0] fl,
                                logic [1:0] fc, logic [7:0] ck, logic [15:0] sc);
        vec_t v;
        v.name = n;
        v.in   = in;
        v.qty  = q;
        v.exp  = {fl, fc, ck, sc};
        return v;
    endfunction

    task automatic compare(input string name, input out_t exp);
        out_t act;
        act = {bus.motor_on, bus.seal_req, bus.refill_req, bus.alarm,
               bus.fault_code, bus.cork_count, bus.sealed_cnt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got motor=%b sreq=%b rreq=%b alarm=%b fc=%0d cork=%0d sealed=%0d, expected motor=%b sreq=%b rreq=%b alarm=%b fc=%0d cork=%0d sealed=%0d",
                     name, act.motor, act.sreq, act.rreq, act.alarm, act.fc, act.cork,
                     act.sealed, exp.motor, exp.sreq, exp.rreq, exp.alarm, exp.fc, exp.cork,
                     exp.sealed);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        {bus.start, bus.clear, bus.bottle, bus.pos, bus.seal_ack, bus.refill_ack} = v.in;
        bus.refill_qty = v.qty;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        compare(v.name, sb.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        {bus.start, bus.clear, bus.bottle, bus.pos, bus.seal_ack, bus.refill_ack} = 6'b0;
        bus.refill_qty = 8'd0;
        reset = 1'b1;
        #1;
        compare("reset_state", '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        {bus.start, bus.clear, bus.bottle, bus.pos, bus.seal_ack, bus.refill_ack} = 6'b0;
        bus.refill_qty = 8'd0;
        repeat (2) @(posedge clk);
        do_reset();

        // Normal cycle, ignored inputs in STOP.
        tbl.push_back(mk("stop_to_empty",   6'b100000, 8'd0, 4'b0011, 2'd0, 8'd0, 16'd0));
        tbl.push_back(mk("refill5_run",     6'b100001, 8'd5, 4'b1000, 2'd0, 8'd5, 16'd0));
        tbl.push_back(mk("bottle_align",    6'b101000, 8'd0, 4'b0000, 2'd0, 8'd5, 16'd0));
        tbl.push_back(mk("align_wait1",     6'b101000, 8'd0, 4'b0000, 2'd0, 8'd5, 16'd0));
        tbl.push_back(mk("align_wait2",     6'b101000, 8'd0, 4'b0000, 2'd0, 8'd5, 16'd0));
        tbl.push_back(mk("pos_seal",        6'b101100, 8'd0, 4'b0100, 2'd0, 8'd5, 16'd0));
        tbl.push_back(mk("seal_wait",       6'b101000, 8'd0, 4'b0100, 2'd0, 8'd5, 16'd0));
        tbl.push_back(mk("ack_release",     6'b101010, 8'd0, 4'b1000, 2'd0, 8'd4, 16'd1));
        tbl.push_back(mk("release_nostart", 6'b001000, 8'd0, 4'b1000, 2'd0, 8'd4, 16'd1));
        tbl.push_back(mk("bottle_gone_run", 6'b100000, 8'd0, 4'b1000, 2'd0, 8'd4, 16'd1));
        tbl.push_back(mk("run_to_stop",     6'b000000, 8'd0, 4'b0000, 2'd0, 8'd4, 16'd1));
        tbl.push_back(mk("stop_ign_refill", 6'b000001, 8'd3, 4'b0000, 2'd0, 8'd4, 16'd1));
        tbl.push_back(mk("stop_ign_ack",    6'b000010, 8'd0, 4'b0000, 2'd0, 8'd4, 16'd1));
        run_tbl();

        // Stock exhaustion, zero refill, saturating refill into STOP.
        do_reset();
        tbl.push_back(mk("b_stop_to_empty", 6'b100000, 8'd0,   4'b0011, 2'd0, 8'd0,   16'd0));
        tbl.push_back(mk("refill_zero",     6'b100001, 8'd0,   4'b0011, 2'd0, 8'd0,   16'd0));
        tbl.push_back(mk("refill1_run",     6'b100001, 8'd1,   4'b1000, 2'd0, 8'd1,   16'd0));
        tbl.push_back(mk("b_align",         6'b101000, 8'd0,   4'b0000, 2'd0, 8'd1,   16'd0));
        tbl.push_back(mk("b_seal",          6'b101100, 8'd0,   4'b0100, 2'd0, 8'd1,   16'd0));
        tbl.push_back(mk("b_release",       6'b101010, 8'd0,   4'b1000, 2'd0, 8'd0,   16'd1));
        tbl.push_back(mk("exhaust_empty",   6'b100000, 8'd0,   4'b0011, 2'd0, 8'd0,   16'd1));
        tbl.push_back(mk("refill_sat_stop", 6'b000001, 8'd200, 4'b0000, 2'd0, 8'd100, 16'd1));
        run_tbl();

        // Align timeout after ALIGN_TO+1 cycles in ALIGN.
        step(mk("c_run",   6'b100000, 8'd0, 4'b1000, 2'd0, 8'd100, 16'd1));
        step(mk("c_align", 6'b101000, 8'd0, 4'b0000, 2'd0, 8'd100, 16'd1));
        for (int i = 0; i < 15; i++) step(mk("c_align_hold", 6'b101000, 8'd0, 4'b0000, 2'd0, 8'd100, 16'd1));
        step(mk("align_timeout", 6'b101000, 8'd0, 4'b0001, 2'd1, 8'd100, 16'd1));
        step(mk("fault_held",    6'b101000, 8'd0, 4'b0001, 2'd1, 8'd100, 16'd1));
        step(mk("clear_to_stop", 6'b011000, 8'd0, 4'b0000, 2'd0, 8'd100, 16'd1));

        // Bottle still present: STOP -> RUN -> ALIGN; pos on the limit cycle wins.
        step(mk("d_run",   6'b101000, 8'd0, 4'b1000, 2'd0, 8'd100, 16'd1));
        step(mk("d_align", 6'b101000, 8'd0, 4'b0000, 2'd0, 8'd100, 16'd1));
        for (int i = 0; i < 15; i++) step(mk("d_align_hold", 6'b101000, 8'd0, 4'b0000, 2'd0, 8'd100, 16'd1));
        step(mk("pos_beats_timeout", 6'b101100, 8'd0, 4'b0100, 2'd0, 8'd100, 16'd1));

        // Seal timeout: no decrement, seal_req drops.
        for (int i = 0; i < 31; i++) step(mk("seal_hold", 6'b101000, 8'd0, 4'b0100, 2'd0, 8'd100, 16'd1));
        step(mk("seal_timeout",   6'b101000, 8'd0, 4'b0001, 2'd2, 8'd100, 16'd1));
        step(mk("clear_seal_flt", 6'b011000, 8'd0, 4'b0000, 2'd0, 8'd100, 16'd1));

        // Async reset in SEAL.
        step(mk("e_run",   6'b101000, 8'd0, 4'b1000, 2'd0, 8'd100, 16'd1));
        step(mk("e_align", 6'b101000, 8'd0, 4'b0000, 2'd0, 8'd100, 16'd1));
        step(mk("e_seal",  6'b101100, 8'd0, 4'b0100, 2'd0, 8'd100, 16'd1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        compare("async_reset_seal", '0);
        @(negedge clk);
        reset = 1'b0;
        {bus.start, bus.clear, bus.bottle, bus.pos, bus.seal_ack, bus.refill_ack} = 6'b0;
        step(mk("post_reset_idle", 6'b000000, 8'd0, 4'b0000, 2'd0, 8'd0, 16'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
